// File: rtl/imem_pkg.sv
// Shared types and defaults for the instruction-memory arbiter.
package imem_pkg;

  localparam int PC_BITS      = 16;
  localparam int MAX_WAIT_DEF = 4;

  // Who owns the read data coming back from memory this cycle.
  typedef enum logic [1:0] {
    NONE  = 2'd0,
    FETCH = 2'd1,
    LOAD  = 2'd2
  } owner_t;

  // Arbitration mode.
  typedef enum logic {
    FETCH_PRI = 1'b0,
    LOCKED    = 1'b1
  } arb_state_t;

endpackage

// File: rtl/imem_resp_tracker.sv
// Return path for the shared memory port. It remembers which requester
// issued the read granted last cycle and steers mem_rdata back to it.
// A fetch return is killed by a flush in the return cycle, and any return
// is dropped while reset is high. The rdata outputs hold the last
// delivered word between returns.
module imem_resp_tracker #(
  parameter int PC_BITS = imem_pkg::PC_BITS
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               f_gnt,
  input  logic               l_gnt,
  input  logic               l_we,
  input  logic               f_flush,
  input  logic [PC_BITS-1:0] mem_rdata,
  output logic               f_rvalid,
  output logic [PC_BITS-1:0] f_rdata,
  output logic               l_rvalid,
  output logic [PC_BITS-1:0] l_rdata
);
  import imem_pkg::*;

  owner_t             owner;
  logic [PC_BITS-1:0] f_hold;
  logic [PC_BITS-1:0] l_hold;

  // Record the owner of next cycle's read data and latch delivered words.
  always_ff @(posedge clk) begin
    if (rst) begin
      owner  <= NONE;
      f_hold <= '0;
      l_hold <= '0;
    end else begin
      if (f_gnt)              owner <= FETCH;
      else if (l_gnt && !l_we) owner <= LOAD;
      else                    owner <= NONE;
      if (f_rvalid) f_hold <= mem_rdata;
      if (l_rvalid) l_hold <= mem_rdata;
    end
  end

  // Memory data is valid in the cycle after the grant, so it is passed
  // straight through and only the hold copy is registered.
  assign f_rvalid = (owner == FETCH) && !f_flush && !rst;
  assign l_rvalid = (owner == LOAD) && !rst;
  assign f_rdata  = f_rvalid ? mem_rdata : f_hold;
  assign l_rdata  = l_rvalid ? mem_rdata : l_hold;

endmodule

// File: rtl/imem_arbiter.sv
// Single-port arbiter sharing the instruction memory between the fetch
// stage (read-only) and the loader/debug port (read/write). Fetch has
// priority, but after MAX_WAIT consecutive contested fetch wins the loader
// is forced through. The loader may lock the port for burst programming.
module imem_arbiter #(
  parameter int PC_BITS  = imem_pkg::PC_BITS,
  parameter int MAX_WAIT = imem_pkg::MAX_WAIT_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               f_req,
  input  logic [PC_BITS-1:0] f_addr,
  input  logic               f_flush,
  output logic               f_gnt,
  output logic               f_rvalid,
  output logic [PC_BITS-1:0] f_rdata,
  input  logic               l_req,
  input  logic               l_we,
  input  logic               l_lock,
  input  logic [PC_BITS-1:0] l_addr,
  input  logic [PC_BITS-1:0] l_wdata,
  output logic               l_gnt,
  output logic               l_rvalid,
  output logic [PC_BITS-1:0] l_rdata,
  output logic               mem_en,
  output logic               mem_we,
  output logic [PC_BITS-1:0] mem_addr,
  output logic [PC_BITS-1:0] mem_wdata,
  input  logic [PC_BITS-1:0] mem_rdata
);
  import imem_pkg::*;

  localparam logic [3:0] WAIT_LIM = 4'(MAX_WAIT);

  arb_state_t state;
  logic [3:0] wait_cnt;
  logic       lock_now;
  logic       f_ok;

  // Grant selection; the lock takes effect in the same cycle it is raised.
  always_comb begin
    f_gnt    = 1'b0;
    l_gnt    = 1'b0;
    lock_now = (state == LOCKED) || (l_lock && l_req);
    f_ok     = f_req && !f_flush;
    if (!rst) begin
      if (lock_now) begin
        l_gnt = l_req;
      end else if (f_ok && l_req) begin
        if (wait_cnt == WAIT_LIM) l_gnt = 1'b1;
        else                      f_gnt = 1'b1;
      end else begin
        f_gnt = f_ok;
        l_gnt = l_req;
      end
    end
  end

  // The granted requester drives the memory port; idle fields read as zero.
  always_comb begin
    mem_en    = f_gnt | l_gnt;
    mem_we    = l_gnt & l_we;
    mem_addr  = '0;
    mem_wdata = '0;
    if (f_gnt)      mem_addr = f_addr;
    else if (l_gnt) mem_addr = l_addr;
    if (mem_we)     mem_wdata = l_wdata;
  end

  // Arbitration FSM and loader starvation counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= FETCH_PRI;
      wait_cnt <= '0;
    end else begin
      case (state)
        FETCH_PRI: begin
          if (l_lock && l_req) begin
            state    <= LOCKED;
            wait_cnt <= '0;
          end else if (l_gnt || !l_req) begin
            wait_cnt <= '0;
          end else if (f_gnt && (wait_cnt != WAIT_LIM)) begin
            wait_cnt <= wait_cnt + 4'd1;
          end
        end
        LOCKED: begin
          wait_cnt <= '0;
          if (!l_lock) state <= FETCH_PRI;
        end
        default: begin
          state    <= FETCH_PRI;
          wait_cnt <= '0;
        end
      endcase
    end
  end

  imem_resp_tracker #(.PC_BITS(PC_BITS)) u_resp (
    .clk       (clk),
    .rst       (rst),
    .f_gnt     (f_gnt),
    .l_gnt     (l_gnt),
    .l_we      (l_we),
    .f_flush   (f_flush),
    .mem_rdata (mem_rdata),
    .f_rvalid  (f_rvalid),
    .f_rdata   (f_rdata),
    .l_rvalid  (l_rvalid),
    .l_rdata   (l_rdata)
  );

endmodule

// File: tb/tb_imem_arbiter.sv
// Bench for imem_arbiter: models a one-cycle read memory behind the port,
// predicts grants per cycle and keeps a scoreboard of expected read data.
module tb_imem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        f_req, f_flush, f_gnt, f_rvalid;
  logic [15:0] f_addr, f_rdata;
  logic        l_req, l_we, l_lock, l_gnt, l_rvalid;
  logic [15:0] l_addr, l_wdata, l_rdata;
  logic        mem_en, mem_we;
  logic [15:0] mem_addr, mem_wdata, mem_rdata;

  logic [15:0] mem     [0:65535];
  logic [15:0] ref_mem [0:65535];
  logic [15:0] f_q[$];
  logic [15:0] l_q[$];
  logic        f_pend = 1'b0;
  logic        l_pend = 1'b0;
  int          total = 0;
  int          bad = 0;
  int          nret = 0;

  always #5 clk = ~clk;

  imem_arbiter dut (
    .clk       (clk),
    .rst       (rst),
    .f_req     (f_req),
    .f_addr    (f_addr),
    .f_flush   (f_flush),
    .f_gnt     (f_gnt),
    .f_rvalid  (f_rvalid),
    .f_rdata   (f_rdata),
    .l_req     (l_req),
    .l_we      (l_we),
    .l_lock    (l_lock),
    .l_addr    (l_addr),
    .l_wdata   (l_wdata),
    .l_gnt     (l_gnt),
    .l_rvalid  (l_rvalid),
    .l_rdata   (l_rdata),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  // Memory behind the arbiter: one-cycle read latency.
  always @(posedge clk) begin
    if (mem_en && mem_we)  mem[mem_addr] <= mem_wdata;
    if (mem_en && !mem_we) mem_rdata <= mem[mem_addr];
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock cycle with the inputs already driven; ef/el are the grants
  // the bench expects this cycle.
  task automatic step(input logic ef, input logic el);
    logic [15:0] d;
    @(negedge clk);
    if (f_pend) begin
      d = f_q.pop_front();
      if (!f_flush && !rst) begin
        chk("f_rvalid", f_rvalid, 1);
        if (f_rvalid) begin
          chk("f_rdata", f_rdata, d);
          nret++;
        end
      end else begin
        chk("f_rvalid_kill", f_rvalid, 0);
      end
    end else begin
      chk("f_rvalid_idle", f_rvalid, 0);
    end
    if (l_pend) begin
      d = l_q.pop_front();
      if (!rst) begin
        chk("l_rvalid", l_rvalid, 1);
        if (l_rvalid) chk("l_rdata", l_rdata, d);
      end else begin
        chk("l_rvalid_kill", l_rvalid, 0);
      end
    end else begin
      chk("l_rvalid_idle", l_rvalid, 0);
    end
    chk("f_gnt", f_gnt, ef);
    chk("l_gnt", l_gnt, el);
    chk("mem_en", mem_en, ef | el);
    if (ef) begin
      chk("mem_addr_f", mem_addr, f_addr);
      chk("mem_we_f", mem_we, 0);
      f_q.push_back(ref_mem[f_addr]);
    end else if (el) begin
      chk("mem_addr_l", mem_addr, l_addr);
      chk("mem_we_l", mem_we, l_we);
      if (l_we) begin
        chk("mem_wdata", mem_wdata, l_wdata);
        ref_mem[l_addr] = l_wdata;
      end else begin
        l_q.push_back(ref_mem[l_addr]);
      end
    end
    f_pend = ef;
    l_pend = el && !l_we;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int a = 0; a < 65536; a++) begin
      mem[a]     = 16'(a) ^ 16'hA5A5;
      ref_mem[a] = 16'(a) ^ 16'hA5A5;
    end
    mem_rdata = '0;
    rst = 1'b1; f_req = 1'b1; f_addr = 16'h0000; f_flush = 1'b0;
    l_req = 1'b1; l_we = 1'b0; l_lock = 1'b0; l_addr = 16'h1234; l_wdata = '0;

    // Reset with both requesting: nothing granted.
    step(0, 0);
    step(0, 0);
    chk("rst_f_rdata", f_rdata, 0);
    chk("rst_l_rdata", l_rdata, 0);
    rst = 1'b0;

    // Contention: F,F,F,F,L repeating; first post-reset cycle grants fetch.
    for (int k = 0; k < 10; k++) begin
      step(k % 5 != 4, k % 5 == 4);
      if (k % 5 != 4) f_addr = f_addr + 16'd1;
    end

    // Fetch-only stream over 0x0000..0x00FF.
    l_req = 1'b0; f_addr = 16'h0000; nret = 0;
    for (int i = 0; i < 256; i++) begin
      step(1, 0);
      f_addr = f_addr + 16'd1;
    end
    f_req = 1'b0;
    step(0, 0);
    chk("fetch_returns", nret, 256);

    // Locked burst write; fetch shut out for the whole lock.
    f_req = 1'b1; f_addr = 16'h0105;
    l_req = 1'b1; l_lock = 1'b1; l_we = 1'b1; l_wdata = 16'hBEEF;
    for (int i = 0; i < 10; i++) begin
      l_addr = 16'h0100 + 16'(i);
      step(0, 1);
    end
    l_lock = 1'b0; l_req = 1'b0; l_we = 1'b0;
    step(0, 0);
    step(1, 0);
    f_req = 1'b0;
    step(0, 0);
    chk("lock_readback", f_rdata, 16'hBEEF);

    // Flush kills the fetch return; loader takes the flush slot.
    f_req = 1'b1; f_addr = 16'h0040;
    step(1, 0);
    f_flush = 1'b1; f_addr = 16'h0041; l_req = 1'b1; l_addr = 16'h0040;
    step(0, 1);
    f_flush = 1'b0; l_req = 1'b0;
    step(1, 0);
    f_req = 1'b0;
    step(0, 0);

    // Mid-operation reset after two contested fetch wins.
    f_req = 1'b1; f_addr = 16'h0050; l_req = 1'b1; l_addr = 16'h0060;
    step(1, 0);
    f_addr = 16'h0051;
    step(1, 0);
    rst = 1'b1; l_we = 1'b1; l_wdata = 16'h1111;
    step(0, 0);
    rst = 1'b0; l_we = 1'b0;
    for (int k = 0; k < 5; k++) begin
      step(k != 4, k == 4);
      if (k != 4) f_addr = f_addr + 16'd1;
    end
    f_req = 1'b0; l_req = 1'b0;
    step(0, 0);
    chk("rst_write_dropped", l_rdata, 16'h0060 ^ 16'hA5A5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/imem_arbiter.md
Name: imem_arbiter

Overview:
Single-port arbiter in front of the 16-bit instruction memory / i_cache array. It shares that memory between the fetch stage (read-only) and the program loader/debug port (read/write). The arbiter applies fixed fetch priority with a bounded-starvation guarantee for the loader, plus a loader lock for burst programming. It tracks ownership of the one-cycle read return and drops fetch returns on flush.

Parameters:
PC_BITS, 16, address and instruction width
MAX_WAIT, 4, consecutive contested fetch grants tolerated before the loader is forced through (range 1..15)

Ports:
clk  in  1  system clock, all state on rising edge
rst  in  1  synchronous active-high reset
f_req  in  1  fetch read request
f_addr  in  PC_BITS  fetch address
f_flush  in  1  fetch redirect; kill in-flight fetch return
f_gnt  out  1  fetch request accepted this cycle (combinational)
f_rvalid  out  1  fetch read data valid (registered)
f_rdata  out  PC_BITS  fetch read data
l_req  in  1  loader request
l_we  in  1  loader write (1) / read (0)
l_lock  in  1  loader holds absolute priority while high
l_addr  in  PC_BITS  loader address
l_wdata  in  PC_BITS  loader write data
l_gnt  out  1  loader request accepted this cycle (combinational)
l_rvalid  out  1  loader read data valid (registered; never for writes)
l_rdata  out  PC_BITS  loader read data
mem_en  out  1  memory access this cycle
mem_we  out  1  memory write strobe
mem_addr  out  PC_BITS  memory address
mem_wdata  out  PC_BITS  memory write data
mem_rdata  in  PC_BITS  memory read data, valid one cycle after a mem_en read

Behaviour:
- Clock and reset: single clock clk. rst is synchronous and active-high, sampled only on the clk rising edge.
- Reset: FSM=FETCH_PRI, wait_cnt=0, resp_owner=NONE, f_rvalid=0, l_rvalid=0, f_rdata=0, l_rdata=0. While rst is high, f_gnt=l_gnt=mem_en=mem_we=0 regardless of requests.
- At most one grant per cycle. The granted requester drives mem_addr/mem_we/mem_wdata combinationally in the same cycle. mem_en=f_gnt|l_gnt. mem_we=l_gnt&l_we. With no grant, mem_addr and mem_wdata are 0.
- Read latency is 1 cycle: a grant in cycle N produces *_rvalid=1 in N+1, with *_rdata=mem_rdata. The rdata outputs hold their last value when rvalid=0.
- Requesters hold req and payload stable until they see gnt. A request is consumed on the cycle gnt=1. Back-to-back grants every cycle are allowed.
- FSM states:
  - FETCH_PRI: if both request, fetch wins, unless wait_cnt==MAX_WAIT, in which case the loader wins. A lone requester always wins. wait_cnt increments on each cycle where both request and fetch wins. wait_cnt clears on any loader grant or whenever l_req=0.
  - LOCKED: entered when l_lock=1 and l_req=1. The loader always wins and fetch gets no grant even if the loader is idle. Exit to FETCH_PRI the cycle after l_lock falls. wait_cnt is held at 0 in this state.
- l_lock=1 with l_req=0 in FETCH_PRI has no effect.
- Flush: f_flush=1 in cycle N+1 forces f_rvalid=0 for a fetch granted in cycle N. f_flush=1 in cycle N also blocks f_gnt in cycle N; the loader may take that slot. f_flush never affects loader traffic.
- Write-then-read of the same address on consecutive cycles returns the new data, provided the memory is write-first; the arbiter does no forwarding.
- wait_cnt saturates at MAX_WAIT and never wraps.
- Reset asserted mid-transaction: an in-flight return is discarded (rvalid=0 the next cycle). A write granted in the reset cycle is not issued.

Decomposition:
- Shared package imem_pkg holds:
  - PC_BITS
  - enum owner_t {NONE, FETCH, LOAD}
  - enum arb_state_t {FETCH_PRI, LOCKED}
  - MAX_WAIT default
- One natural sub-module, imem_resp_tracker: the registered owner/rvalid/rdata return path, including flush kill.
- Grant logic and the FSM stay in the top-level module.

Test Plan:
- Reset with f_req=1, l_req=1 held high → f_gnt=l_gnt=mem_en=0, both rvalid=0. The first cycle after rst falls gives f_gnt=1.
- Fetch only, addresses 0x0000..0x00FF back-to-back, memory preloaded with mem[a]=a^16'hA5A5 → f_gnt=1 every cycle; f_rvalid=1 from the 2nd cycle with f_rdata=addr^0xA5A5 of the previous cycle; 256 returns total.
- Contention with MAX_WAIT=4: f_req and l_req held high → grant pattern F,F,F,F,L repeating. The loader read of 0x1234 returns l_rvalid=1 one cycle after its grant.
- Loader lock: l_lock=1 with l_req=1 for 10 writes of 0xBEEF to 0x0100..0x0109, f_req=1 throughout → zero f_gnt during the lock. Fetch of 0x0105 after unlock returns 0xBEEF.
- Flush: fetch granted at 0x0040, then f_flush=1 the next cycle → f_rvalid=0 that cycle. A pending loader read in the flush cycle gets l_gnt=1.
- Mid-operation reset: rst=1 in the cycle after a fetch grant → f_rvalid=0, wait_cnt=0, FSM=FETCH_PRI.
